// File: rtl/gpr_file_scrub_if.sv
// Bus bundle for the scrubbing register file: write port, two read ports and clear control.
interface gpr_file_scrub_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                  w_en;
   logic [ADDR_W-1:0]     w_addr;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_be;
   logic [ADDR_W-1:0]     ra_addr;
   logic [DATA_W-1:0]     ra_data;
   logic [ADDR_W-1:0]     rb_addr;
   logic [DATA_W-1:0]     rb_data;
   logic                  clr_req;
   logic                  busy;
   logic                  done;

   modport master (
      output w_en, w_addr, w_data, w_be, ra_addr, rb_addr, clr_req,
      input  ra_data, rb_data, busy, done
   );

   modport slave (
      input  w_en, w_addr, w_data, w_be, ra_addr, rb_addr, clr_req,
      output ra_data, rb_data, busy, done
   );
endinterface

// File: rtl/gpr_file_scrub.sv
// 2-read/1-write register file with byte enables, optional bypass, hardwired zero entry
// and a scrub engine that clears one entry per cycle after reset or on request.
module gpr_file_scrub #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           clk,
   input  logic           rst,
   gpr_file_scrub_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, SCRUB} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic                done_q, done_nxt;
   logic                busy;
   logic                wr_ok;
   logic [DATA_W-1:0]   wr_merged;
   logic [DATA_W-1:0]   mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SCRUB;
         ptr    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr_req) begin
               state_nxt = SCRUB;
               ptr_nxt   = '0;
            end
         end
         SCRUB: begin
            if (ptr == LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         default: state_nxt = SCRUB;
      endcase
   end

   assign busy     = (state == SCRUB);
   assign bus.busy = busy;
   assign bus.done = done_q;

   assign wr_ok = bus.w_en && !busy && !((ZERO_REG != 0) && (bus.w_addr == '0));

   // Old entry with enabled bytes replaced; feeds both the array write and the bypass path.
   always_comb begin
      wr_merged = mem[bus.w_addr];
      for (int i = 0; i < NB; i++) begin
         if (bus.w_be[i]) wr_merged[8*i +: 8] = bus.w_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy)       mem[ptr]        <= '0;
         else if (wr_ok) mem[bus.w_addr] <= wr_merged;
      end
   end

   always_comb begin
      if (busy)
         bus.ra_data = '0;
      else if ((ZERO_REG != 0) && (bus.ra_addr == '0))
         bus.ra_data = '0;
      else if ((BYPASS != 0) && wr_ok && (bus.ra_addr == bus.w_addr))
         bus.ra_data = wr_merged;
      else
         bus.ra_data = mem[bus.ra_addr];
   end

   always_comb begin
      if (busy)
         bus.rb_data = '0;
      else if ((ZERO_REG != 0) && (bus.rb_addr == '0))
         bus.rb_data = '0;
      else if ((BYPASS != 0) && wr_ok && (bus.rb_addr == bus.w_addr))
         bus.rb_data = wr_merged;
      else
         bus.rb_data = mem[bus.rb_addr];
   end
endmodule

// File: tb/tb_gpr_file_scrub.sv
// Directed bench: a bypassing and a non-bypassing register file driven with identical stimulus.
module tb_gpr_file_scrub;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gpr_file_scrub_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
   gpr_file_scrub_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

   gpr_file_scrub #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );
   gpr_file_scrub #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .bus(bus_n)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [4:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input logic clr);
      bus_b.w_en = en;  bus_b.w_addr = addr;  bus_b.w_data = data;  bus_b.w_be = be;  bus_b.clr_req = clr;
      bus_n.w_en = en;  bus_n.w_addr = addr;  bus_n.w_data = data;  bus_n.w_be = be;  bus_n.clr_req = clr;
   endtask

   task automatic setReads(input logic [4:0] a, input logic [4:0] b);
      bus_b.ra_addr = a;  bus_b.rb_addr = b;
      bus_n.ra_addr = a;  bus_n.rb_addr = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run until the bypassing instance leaves SCRUB; returns busy cycles and done pulses seen.
   task automatic countBusy(output int n, output int pulses);
      n = 0;
      pulses = 0;
      while (bus_b.busy && n < 100) begin
         tick();
         n++;
         if (bus_b.done) pulses++;
      end
   endtask

   initial begin
      int n;
      int pulses;
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      setReads(5'd0, 5'd0);

      // T1 reset
      rst = 1'b1;
      tick();
      checkOutput("busy_in_reset", 32'(bus_b.busy), 32'd1);
      checkOutput("done_in_reset", 32'(bus_b.done), 32'd0);
      tick();
      rst = 1'b0;
      countBusy(n, pulses);
      checkOutput("reset_busy_cycles", 32'(n), 32'd32);
      checkOutput("reset_done_pulse", 32'(bus_b.done), 32'd1);
      checkOutput("reset_done_n", 32'(bus_n.done), 32'd1);
      tick();
      checkOutput("reset_done_drop", 32'(bus_b.done), 32'd0);
      for (int a = 0; a < 32; a++) begin
         setReads(5'(a), 5'(31 - a));
         checkOutput($sformatf("reset_zero_a%0d", a), bus_b.ra_data, 32'h0);
         checkOutput($sformatf("reset_zero_b%0d", a), bus_n.rb_data, 32'h0);
      end

      // T2 byte write
      setReads(5'd5, 5'd5);
      applyStimulus(1'b1, 5'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
      #1;
      checkOutput("t2_bypass_full", bus_b.ra_data, 32'hAABBCCDD);
      tick();
      applyStimulus(1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0);
      #1;
      checkOutput("t2_bypass_partial", bus_b.rb_data, 32'hAA22CC44);
      checkOutput("t2_nobypass_old", bus_n.ra_data, 32'hAABBCCDD);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("t2_merged_a", bus_b.ra_data, 32'hAA22CC44);
      checkOutput("t2_merged_n", bus_n.rb_data, 32'hAA22CC44);
      applyStimulus(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("t2_be_zero_noop", bus_b.ra_data, 32'hAA22CC44);

      // T3 zero register
      setReads(5'd0, 5'd0);
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111, 1'b0);
      #1;
      checkOutput("t3_zero_a_wr", bus_b.ra_data, 32'h0);
      checkOutput("t3_zero_b_wr", bus_b.rb_data, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("t3_zero_a_after", bus_b.ra_data, 32'h0);
      checkOutput("t3_zero_b_after", bus_n.rb_data, 32'h0);

      // T4 bypass vs no bypass
      applyStimulus(1'b1, 5'd7, 32'h12345678, 4'b1111, 1'b0);
      tick();
      setReads(5'd7, 5'd5);
      applyStimulus(1'b1, 5'd7, 32'hFFFFFFFF, 4'b0011, 1'b0);
      #1;
      checkOutput("t4_bypass", bus_b.ra_data, 32'h1234FFFF);
      checkOutput("t4_nobypass_wr", bus_n.ra_data, 32'h12345678);
      checkOutput("t4_other_port", bus_b.rb_data, 32'hAA22CC44);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("t4_nobypass_next", bus_n.ra_data, 32'h1234FFFF);

      // T5 clear request
      for (int a = 1; a < 32; a++) begin
         applyStimulus(1'b1, 5'(a), 32'hA5000000 | 32'(a), 4'b1111, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      setReads(5'd31, 5'd3);
      checkOutput("t5_filled_31", bus_b.ra_data, 32'hA500001F);
      checkOutput("t5_filled_3", bus_n.rb_data, 32'hA5000003);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("t5_busy", 32'(bus_b.busy), 32'd1);
      checkOutput("t5_read_busy", bus_b.ra_data, 32'h0);
      n = 0;
      pulses = 0;
      while (bus_b.busy && n < 100) begin
         if (n == 10) applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 4'b1111, 1'b1);
         if (n == 11) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
         tick();
         n++;
         if (bus_b.done) pulses++;
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      checkOutput("t5_busy_cycles", 32'(n), 32'd32);
      checkOutput("t5_done", 32'(bus_b.done), 32'd1);
      for (int a = 0; a < 32; a++) begin
         setReads(5'(a), 5'(a));
         checkOutput($sformatf("t5_clear_a%0d", a), bus_b.ra_data, 32'h0);
      end
      setReads(5'd3, 5'd3);
      checkOutput("t5_dropped_wr", bus_n.rb_data, 32'h0);

      // T6 reset mid-scrub
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 10; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      countBusy(n, pulses);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus_b.done) pulses++;
      end
      checkOutput("t6_busy_cycles", 32'(n), 32'd32);
      checkOutput("t6_done_once", 32'(pulses), 32'd1);
      checkOutput("t6_idle", 32'(bus_n.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
